// File: rtl/pcie_lpif_pkg.sv
// Shared types for the LPIF transmit-side packer: beat layout, FSM states,
// and marker selection helper.
package pcie_lpif_pkg;

   localparam int LPIF_BYTES = 64;
   localparam int LPIF_IW    = $clog2(LPIF_BYTES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      STALL = 2'd2
   } pack_state_e;

   typedef enum logic {
      MK_TLP  = 1'b0,
      MK_DLLP = 1'b1
   } mk_type_e;

   typedef struct packed {
      logic [LPIF_BYTES-1:0][7:0] data;
      logic [LPIF_BYTES-1:0]      valid;
      logic [LPIF_BYTES-1:0]      tlpstart;
      logic [LPIF_BYTES-1:0]      tlpend;
      logic [LPIF_BYTES-1:0]      dlpstart;
      logic [LPIF_BYTES-1:0]      dlpend;
   } lpif_beat_t;

   // Sets the start or end marker of the selected packet type at byte idx.
   function automatic lpif_beat_t mark_beat(input lpif_beat_t b, input mk_type_e t,
                                            input logic is_end, input logic [LPIF_IW-1:0] idx);
      lpif_beat_t r;
      r = b;
      case ({t, is_end})
         {MK_TLP,  1'b0}: r.tlpstart[idx] = 1'b1;
         {MK_TLP,  1'b1}: r.tlpend[idx]   = 1'b1;
         {MK_DLLP, 1'b0}: r.dlpstart[idx] = 1'b1;
         default:         r.dlpend[idx]   = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lpif_out_stage.sv
// Single-entry holding register for LPIF beats; holds lp_* stable until
// the downstream accepts with trdy.
module lpif_out_stage
   import pcie_lpif_pkg::*;
(
   input  logic       pclk,
   input  logic       reset_n,
   input  logic       i_load,
   input  lpif_beat_t i_beat,
   input  logic       i_trdy,
   output lpif_beat_t o_beat,
   output logic       o_irdy,
   output logic       o_empty_or_draining
);

   lpif_beat_t r_beat;
   logic       r_irdy;

   assign o_beat              = r_beat;
   assign o_irdy              = r_irdy;
   assign o_empty_or_draining = !r_irdy || i_trdy;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_beat <= '0;
         r_irdy <= 1'b0;
      end else if (i_load) begin
         r_beat <= i_beat;
         r_irdy <= 1'b1;
      end else if (r_irdy && i_trdy) begin
         r_irdy <= 1'b0;
      end
   end

endmodule

// File: rtl/lpif_tx_packer.sv
// Packs valid/ready byte-stream packets (TLP/DLLP) into 64-byte LPIF beats.
//   state | meaning
//   IDLE  | no packet open; a word without sop is dropped with err
//   FILL  | packet open, fill buffer partially written at wp
//   STALL | fill buffer closed, waiting for the output register to free up
module lpif_tx_packer
   import pcie_lpif_pkg::*;
#(
   parameter int IN_BYTES  = 4,
   parameter int OUT_BYTES = LPIF_BYTES
) (
   input  logic                         pclk,
   input  logic                         reset_n,
   input  logic [8*IN_BYTES-1:0]        in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sop,
   input  logic                         in_eop,
   input  logic                         in_dllp,
   input  logic [$clog2(IN_BYTES):0]    in_nbytes,
   output logic [8*OUT_BYTES-1:0]       lp_data,
   output logic [OUT_BYTES-1:0]         lp_valid,
   output logic [OUT_BYTES-1:0]         lp_tlpstart,
   output logic [OUT_BYTES-1:0]         lp_tlpend,
   output logic [OUT_BYTES-1:0]         lp_dlpstart,
   output logic [OUT_BYTES-1:0]         lp_dlpend,
   output logic                         lp_irdy,
   input  logic                         pl_trdy,
   output logic                         err
);

   localparam int                NB_W    = $clog2(IN_BYTES) + 1;
   localparam int                WP_W    = LPIF_IW;
   localparam logic [NB_W-1:0]   NB_FULL = NB_W'(IN_BYTES);
   localparam logic [WP_W-1:0]   WP_LAST = WP_W'(OUT_BYTES - IN_BYTES);
   localparam logic [WP_W-1:0]   WP_STEP = WP_W'(IN_BYTES);

   pack_state_e     r_state;
   logic [WP_W-1:0] r_wp;
   lpif_beat_t      r_fill;
   mk_type_e        r_type;
   logic            r_stall_eop;
   logic            r_in_ready;
   logic            r_err;

   logic            w_acc;
   logic            w_word;
   logic            w_err;
   logic            w_close;
   logic            w_oe;
   logic            w_load;
   logic [WP_W-1:0] w_wp;
   logic [NB_W-1:0] w_nb;
   mk_type_e        w_type;
   lpif_beat_t      w_beat;
   lpif_beat_t      w_load_beat;
   lpif_beat_t      w_out;

   // w_beat is the fill buffer as it looks with the current word merged in;
   // a sop word starts from a clean buffer, which also discards a partial beat.
   always_comb begin
      w_acc  = in_valid && r_in_ready;
      w_word = w_acc && (in_sop || (r_state == FILL));
      w_err  = w_acc && (in_sop ? (r_state == FILL) : (r_state == IDLE));
      w_wp   = in_sop ? '0 : r_wp;
      w_type = in_sop ? mk_type_e'(in_dllp) : r_type;
      w_nb   = (!in_eop || (in_nbytes == '0) || (in_nbytes > NB_FULL)) ? NB_FULL : in_nbytes;
      w_beat = in_sop ? '0 : r_fill;
      for (int i = 0; i < IN_BYTES; i++) begin
         w_beat.data[w_wp + WP_W'(i)] = in_data[i*8 +: 8];
         if (i < int'(w_nb)) w_beat.valid[w_wp + WP_W'(i)] = 1'b1;
      end
      if (in_sop) w_beat = mark_beat(w_beat, w_type, 1'b0, '0);
      if (in_eop) w_beat = mark_beat(w_beat, w_type, 1'b1, w_wp + WP_W'(w_nb) - WP_W'(1));
      w_close     = w_word && (in_eop || (w_wp == WP_LAST));
      w_load      = w_oe && (w_close || (r_state == STALL));
      w_load_beat = (r_state == STALL) ? r_fill : w_beat;
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_wp        <= '0;
         r_fill      <= '0;
         r_type      <= MK_TLP;
         r_stall_eop <= 1'b0;
         r_in_ready  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err      <= w_err;
         r_in_ready <= 1'b1;
         case (r_state)
            IDLE, FILL: begin
               if (w_word) begin
                  r_type <= w_type;
                  if (w_close && w_oe) begin
                     r_fill  <= '0;
                     r_wp    <= '0;
                     r_state <= in_eop ? IDLE : FILL;
                  end else if (w_close) begin
                     r_fill      <= w_beat;
                     r_stall_eop <= in_eop;
                     r_state     <= STALL;
                     r_in_ready  <= 1'b0;
                  end else begin
                     r_fill  <= w_beat;
                     r_wp    <= w_wp + WP_STEP;
                     r_state <= FILL;
                  end
               end
            end
            STALL: begin
               if (w_oe) begin
                  r_fill  <= '0;
                  r_wp    <= '0;
                  r_state <= r_stall_eop ? IDLE : FILL;
               end else begin
                  r_in_ready <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   lpif_out_stage u_out (
      .pclk                (pclk),
      .reset_n             (reset_n),
      .i_load              (w_load),
      .i_beat              (w_load_beat),
      .i_trdy              (pl_trdy),
      .o_beat              (w_out),
      .o_irdy              (lp_irdy),
      .o_empty_or_draining (w_oe)
   );

   assign in_ready    = r_in_ready;
   assign err         = r_err;
   assign lp_data     = w_out.data;
   assign lp_valid    = w_out.valid;
   assign lp_tlpstart = w_out.tlpstart;
   assign lp_tlpend   = w_out.tlpend;
   assign lp_dlpstart = w_out.dlpstart;
   assign lp_dlpend   = w_out.dlpend;

endmodule

// File: tb/tb_lpif_tx_packer.sv
// Directed bench for lpif_tx_packer with IN_BYTES=4: single/multi-beat
// packets, backpressure, protocol errors and reset during a stall.
module tb_lpif_tx_packer;

   logic         pclk;
   logic         reset_n;
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_ready;
   logic         in_sop;
   logic         in_eop;
   logic         in_dllp;
   logic [2:0]   in_nbytes;
   logic [511:0] lp_data;
   logic [63:0]  lp_valid;
   logic [63:0]  lp_tlpstart;
   logic [63:0]  lp_tlpend;
   logic [63:0]  lp_dlpstart;
   logic [63:0]  lp_dlpend;
   logic         lp_irdy;
   logic         pl_trdy;
   logic         err;

   int n_cmp = 0;
   int n_bad = 0;

   lpif_tx_packer #(.IN_BYTES(4), .OUT_BYTES(64)) dut (
      .pclk        (pclk),
      .reset_n     (reset_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sop      (in_sop),
      .in_eop      (in_eop),
      .in_dllp     (in_dllp),
      .in_nbytes   (in_nbytes),
      .lp_data     (lp_data),
      .lp_valid    (lp_valid),
      .lp_tlpstart (lp_tlpstart),
      .lp_tlpend   (lp_tlpend),
      .lp_dlpstart (lp_dlpstart),
      .lp_dlpend   (lp_dlpend),
      .lp_irdy     (lp_irdy),
      .pl_trdy     (pl_trdy),
      .err         (err)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // Presents one word and holds it until accepted (bounded wait).
   task automatic send(input logic sop, input logic eop, input logic dllp,
                       input logic [2:0] nb, input logic [31:0] d);
      int   n;
      logic acc;
      in_valid  = 1'b1;
      in_sop    = sop;
      in_eop    = eop;
      in_dllp   = dllp;
      in_nbytes = nb;
      in_data   = d;
      n = 0;
      do begin
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 100);
      check("word_accept", acc, 1);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_dllp  = 1'b0;
   endtask

   logic [511:0] e;
   logic [511:0] e_a;
   logic [31:0]  d;

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_sop    = 1'b0;
      in_eop    = 1'b0;
      in_dllp   = 1'b0;
      in_nbytes = 3'd0;
      in_data   = 32'h0;
      pl_trdy   = 1'b1;
      repeat (3) @(posedge pclk);
      #1;
      check("rst_irdy", lp_irdy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_err", err, 0);
      check("rst_valid", lp_valid, 0);
      check("rst_data", lp_data, 0);
      check("rst_tlpstart", lp_tlpstart, 0);
      reset_n = 1'b1;
      tick();
      check("ready_after_rst", in_ready, 1);

      // 12-byte TLP
      send(1'b1, 1'b0, 1'b0, 3'd4, 32'h03020100);
      check("t1_irdy_mid", lp_irdy, 0);
      send(1'b0, 1'b0, 1'b0, 3'd4, 32'h07060504);
      send(1'b0, 1'b1, 1'b0, 3'd4, 32'h0B0A0908);
      e = '0;
      e[95:0] = 96'h0B0A0908_07060504_03020100;
      check("t1_irdy", lp_irdy, 1);
      check("t1_valid", lp_valid, 64'h0FFF);
      check("t1_tlpstart", lp_tlpstart, 64'h1);
      check("t1_tlpend", lp_tlpend, 64'h800);
      check("t1_dlpstart", lp_dlpstart, 0);
      check("t1_data", lp_data, e);
      tick();
      check("t1_irdy_drop", lp_irdy, 0);

      // 8-byte DLLP then back-to-back 4-byte TLP
      send(1'b1, 1'b0, 1'b1, 3'd4, 32'h13121110);
      send(1'b0, 1'b1, 1'b1, 3'd4, 32'h17161514);
      e = '0;
      e[63:0] = 64'h17161514_13121110;
      check("t2a_irdy", lp_irdy, 1);
      check("t2a_valid", lp_valid, 64'hFF);
      check("t2a_dlpstart", lp_dlpstart, 64'h1);
      check("t2a_dlpend", lp_dlpend, 64'h80);
      check("t2a_tlpstart", lp_tlpstart, 0);
      check("t2a_data", lp_data, e);
      send(1'b1, 1'b1, 1'b0, 3'd4, 32'h23222120);
      e = '0;
      e[31:0] = 32'h23222120;
      check("t2b_irdy", lp_irdy, 1);
      check("t2b_valid", lp_valid, 64'hF);
      check("t2b_tlpstart", lp_tlpstart, 64'h1);
      check("t2b_tlpend", lp_tlpend, 64'h8);
      check("t2b_dlpstart", lp_dlpstart, 0);
      check("t2b_dlpend", lp_dlpend, 0);
      check("t2b_data", lp_data, e);
      tick();
      check("t2_irdy_drop", lp_irdy, 0);

      // 72-byte TLP spanning two beats
      for (int k = 0; k < 18; k++) begin
         for (int j = 0; j < 4; j++) d[j*8 +: 8] = 8'(4*k + j);
         send(k == 0, k == 17, 1'b0, 3'd4, d);
         if (k == 15) begin
            check("t3a_irdy", lp_irdy, 1);
            check("t3a_valid", lp_valid, {64{1'b1}});
            check("t3a_tlpstart", lp_tlpstart, 64'h1);
            check("t3a_tlpend", lp_tlpend, 0);
            check("t3a_byte63", lp_data[511:504], 8'h3F);
            check("t3a_byte0", lp_data[7:0], 8'h00);
         end
         if (k == 16) check("t3_irdy_gap", lp_irdy, 0);
      end
      e = '0;
      e[63:0] = 64'h47464544_43424140;
      check("t3b_irdy", lp_irdy, 1);
      check("t3b_valid", lp_valid, 64'hFF);
      check("t3b_tlpstart", lp_tlpstart, 0);
      check("t3b_tlpend", lp_tlpend, 64'h80);
      check("t3b_data", lp_data, e);
      tick();
      check("t3_irdy_drop", lp_irdy, 0);

      // Backpressure: two packets stack up, then drain in order
      pl_trdy = 1'b0;
      send(1'b1, 1'b1, 1'b0, 3'd4, 32'hA3A2A1A0);
      e_a = '0;
      e_a[31:0] = 32'hA3A2A1A0;
      check("t4_irdy_a", lp_irdy, 1);
      check("t4_ready_a", in_ready, 1);
      send(1'b1, 1'b1, 1'b1, 3'd2, 32'hB3B2B1B0);
      check("t4_ready_stall", in_ready, 0);
      check("t4_data_hold1", lp_data, e_a);
      repeat (17) tick();
      check("t4_data_hold2", lp_data, e_a);
      check("t4_valid_hold", lp_valid, 64'hF);
      check("t4_irdy_hold", lp_irdy, 1);
      check("t4_ready_hold", in_ready, 0);
      pl_trdy = 1'b1;
      tick();
      e = '0;
      e[31:0] = 32'hB3B2B1B0;
      check("t4_irdy_b", lp_irdy, 1);
      check("t4_data_b", lp_data, e);
      check("t4_valid_b", lp_valid, 64'h3);
      check("t4_dlpstart_b", lp_dlpstart, 64'h1);
      check("t4_dlpend_b", lp_dlpend, 64'h2);
      check("t4_ready_back", in_ready, 1);
      tick();
      check("t4_irdy_drop", lp_irdy, 0);

      // sop in the middle of a packet
      send(1'b1, 1'b0, 1'b0, 3'd4, 32'hC3C2C1C0);
      check("t5_err_idle", err, 0);
      send(1'b1, 1'b0, 1'b0, 3'd4, 32'hD3D2D1D0);
      check("t5_err_pulse", err, 1);
      check("t5_no_beat", lp_irdy, 0);
      send(1'b0, 1'b1, 1'b0, 3'd4, 32'hD7D6D5D4);
      e = '0;
      e[63:0] = 64'hD7D6D5D4_D3D2D1D0;
      check("t5_err_clear", err, 0);
      check("t5_irdy", lp_irdy, 1);
      check("t5_data", lp_data, e);
      check("t5_valid", lp_valid, 64'hFF);
      check("t5_tlpstart", lp_tlpstart, 64'h1);
      check("t5_tlpend", lp_tlpend, 64'h80);
      tick();
      check("t5_irdy_drop", lp_irdy, 0);

      // Non-sop word while idle is dropped; then nbytes=0 means full word
      send(1'b0, 1'b1, 1'b0, 3'd4, 32'hEEEEEEEE);
      check("t6_err_pulse", err, 1);
      check("t6_no_beat", lp_irdy, 0);
      tick();
      check("t6_err_clear", err, 0);
      check("t6_still_none", lp_irdy, 0);
      send(1'b1, 1'b1, 1'b0, 3'd0, 32'hF3F2F1F0);
      e = '0;
      e[31:0] = 32'hF3F2F1F0;
      check("t6_irdy", lp_irdy, 1);
      check("t6_valid_nb0", lp_valid, 64'hF);
      check("t6_tlpend_nb0", lp_tlpend, 64'h8);
      check("t6_data", lp_data, e);
      tick();
      check("t6_irdy_drop", lp_irdy, 0);

      // Reset asserted while stalled
      pl_trdy = 1'b0;
      send(1'b1, 1'b1, 1'b0, 3'd4, 32'h11111111);
      send(1'b1, 1'b1, 1'b0, 3'd4, 32'h22222222);
      check("t7_stalled", in_ready, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("t7_rst_irdy", lp_irdy, 0);
      check("t7_rst_ready", in_ready, 0);
      check("t7_rst_valid", lp_valid, 0);
      repeat (2) @(posedge pclk);
      #1;
      reset_n = 1'b1;
      pl_trdy = 1'b1;
      send(1'b1, 1'b0, 1'b0, 3'd4, 32'h33323130);
      check("t7_no_old_beat", lp_irdy, 0);
      send(1'b0, 1'b1, 1'b0, 3'd3, 32'h37363534);
      e = '0;
      e[63:0] = 64'h37363534_33323130;
      check("t7_irdy", lp_irdy, 1);
      check("t7_valid", lp_valid, 64'h7F);
      check("t7_tlpstart", lp_tlpstart, 64'h1);
      check("t7_tlpend", lp_tlpend, 64'h40);
      check("t7_data", lp_data, e);
      tick();
      check("t7_irdy_drop", lp_irdy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lpif_tx_packer.md
Name: lpif_tx_packer

Overview:
- Link-layer-side stage that sits directly upstream of the TX top.
- Accepts narrow byte-stream packets (TLPs and DLLPs) from the data link layer over a valid/ready interface.
- Packs them into 64-byte LPIF beats with per-byte valid and start/end markers.
- Presents the beats on lp_data/lp_valid/lp_*start/lp_*end with the lp_irdy/pl_trdy handshake.

Parameters:
- IN_BYTES, 4, bytes per input word; power of two; must divide OUT_BYTES.
- OUT_BYTES, 64, bytes per LPIF beat; fixed by the 512-bit lp_data.

Ports:
- pclk  input  1  clock.
- reset_n  input  1  reset.
- in_data  input  8*IN_BYTES  packet bytes; byte 0 in bits [7:0], transmitted first.
- in_valid  input  1  in_data holds a word.
- in_ready  output  1  packer accepts the word this cycle.
- in_sop  input  1  first word of a packet.
- in_eop  input  1  last word of a packet.
- in_dllp  input  1  packet is a DLLP (0 = TLP); sampled with in_sop.
- in_nbytes  input  $clog2(IN_BYTES)+1  valid bytes in the eop word; range 1..IN_BYTES.
- lp_data  output  8*OUT_BYTES  packed beat.
- lp_valid  output  OUT_BYTES  per-byte valid.
- lp_tlpstart / lp_tlpend / lp_dlpstart / lp_dlpend  output  OUT_BYTES each  per-byte markers.
- lp_irdy  output  1  beat valid.
- pl_trdy  input  1  downstream accepts the beat.
- err  output  1  one-cycle protocol-error pulse.

Behaviour:
- Clock and reset: one clock, pclk. Reset is asynchronous and active-low (reset_n).
- Reset values: all lp_* outputs 0, lp_irdy 0, in_ready 0, err 0. Internal state goes to IDLE with fill pointer 0 and both buffers empty.
- in_ready rises in the first cycle after reset deassertion.
- Handshakes:
  - An input word transfers when in_valid && in_ready.
  - A beat transfers when lp_irdy && pl_trdy.
  - lp_* are held stable while lp_irdy=1 and pl_trdy=0.
- Buffering: two stages.
  - Fill buffer: byte pointer wp, 0..OUT_BYTES-IN_BYTES in steps of IN_BYTES.
  - Output register: drives lp_*.
- States:
  - IDLE: no packet open.
  - FILL: packet open.
  - STALL: fill buffer closed and waiting for the output register.
- Word placement: an accepted word is written at bytes wp..wp+IN_BYTES-1. On in_eop, only the first in_nbytes bytes get lp_valid=1. in_nbytes=0 is treated as IN_BYTES.
- Packet alignment: every packet starts at byte 0 of a fresh beat. Beats never mix two packets.
- Markers:
  - On sop: start bit [0] set (tlpstart or dlpstart according to in_dllp).
  - On eop: end bit at byte wp+in_nbytes-1 set.
  - A multi-beat packet carries start only in its first beat and end only in its last.
- A beat closes when:
  - the eop word is accepted, or
  - wp reaches OUT_BYTES-IN_BYTES and a word is accepted (full).
- On close:
  - The fill buffer moves to the output register in the same edge if the output register is empty or being drained this cycle (lp_irdy && pl_trdy).
  - Otherwise the state goes to STALL and in_ready=0 until the move happens.
  - After the move, wp=0; the next state is IDLE after eop, FILL otherwise.
- Latency: eop/full word accepted at edge N → lp_irdy=1 after edge N. Back-to-back beats are possible; throughput is 1 beat per cycle when pl_trdy=1.
- Errors:
  - in_sop while in FILL: err pulses; the partial beat is discarded with no lp output; the new packet starts at wp=0.
  - Word without in_sop while IDLE: word is dropped (in_ready=1), err pulses.
  - in_sop && in_eop in the same word is legal (single-word packet).
- Reset mid-operation: the partial packet and any held beat are lost; lp_irdy drops asynchronously.

Decomposition:
- Shared package pcie_lpif_pkg:
  - LPIF_BYTES=64.
  - state enum {IDLE, FILL, STALL}.
  - marker-type constants for the TLP/DLLP start/end selection.
- Sub-module lpif_out_stage: single-entry holding register with the irdy/trdy handshake. It exposes load/empty_or_draining to the packer FSM.

Test Plan:
- Single 12-byte TLP (3 words, IN_BYTES=4), pl_trdy=1 → one beat:
  - lp_valid=0x0FFF, lp_tlpstart bit0=1, lp_tlpend bit11=1.
  - lp_irdy high for 1 cycle, one cycle after the eop word.
- 8-byte DLLP with in_nbytes=4 on eop, followed immediately by a 4-byte TLP → two beats:
  - beat 1: dlpstart bit0, dlpend bit7.
  - beat 2: tlpstart bit0, tlpend bit3.
  - No byte sharing between the beats.
- 72-byte TLP → beat 1: lp_valid all ones, start only. Beat 2: lp_valid=0xFF, tlpend bit7, no start.
- pl_trdy=0 for 20 cycles while two packets arrive:
  - in_ready drops once both buffers are full (STALL).
  - lp_data stays stable.
  - On pl_trdy=1, both beats drain in order with no loss.
- Error cases:
  - in_sop mid-packet → err=1 for one cycle; the first packet produces no beat; the second packet is emitted normally.
  - Non-sop word while IDLE → err pulse, word dropped.
- Assert reset_n=0 during STALL → lp_irdy=0 and in_ready=0 immediately. After release, a new packet is emitted correctly starting at byte 0.
